// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and flag bit positions for the alu_mdu execute unit.
package alu_pkg;

  localparam logic [4:0] OpAdd    = 5'd0;
  localparam logic [4:0] OpSub    = 5'd1;
  localparam logic [4:0] OpAnd    = 5'd2;
  localparam logic [4:0] OpOr     = 5'd3;
  localparam logic [4:0] OpSlt    = 5'd4;
  localparam logic [4:0] OpSll    = 5'd5;
  localparam logic [4:0] OpSltu   = 5'd6;
  localparam logic [4:0] OpXor    = 5'd7;
  localparam logic [4:0] OpSrl    = 5'd8;
  localparam logic [4:0] OpSra    = 5'd9;
  localparam logic [4:0] OpMul    = 5'd10;
  localparam logic [4:0] OpMulh   = 5'd11;
  localparam logic [4:0] OpMulhsu = 5'd12;
  localparam logic [4:0] OpMulhu  = 5'd13;
  localparam logic [4:0] OpDiv    = 5'd14;
  localparam logic [4:0] OpDivu   = 5'd15;
  localparam logic [4:0] OpRem    = 5'd16;
  localparam logic [4:0] OpRemu   = 5'd17;
  // Reserved codes: zero result, Z flag set, single-cycle latency.
  localparam logic [4:0] OpRsv18 = 5'd18, OpRsv19 = 5'd19, OpRsv20 = 5'd20, OpRsv21 = 5'd21;
  localparam logic [4:0] OpRsv22 = 5'd22, OpRsv23 = 5'd23, OpRsv24 = 5'd24, OpRsv25 = 5'd25;
  localparam logic [4:0] OpRsv26 = 5'd26, OpRsv27 = 5'd27, OpRsv28 = 5'd28, OpRsv29 = 5'd29;
  localparam logic [4:0] OpRsv30 = 5'd30, OpRsv31 = 5'd31;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

endpackage

// File: rtl/alu_mdu_divider.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
module alu_mdu_divider #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);

  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  quo_q, rem_q, dsor_q;
  logic [XLEN-1:0]  quo_n, rem_n;
  logic [XLEN:0]    rem_shift, diff;
  logic             ge;

  // Partial remainder stays below the divisor, so XLEN bits always hold it.
  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign diff      = rem_shift - {1'b0, dsor_q};
  assign ge        = ~diff[XLEN];
  assign rem_n     = ge ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
  assign quo_n     = {quo_q[XLEN-2:0], ge};

  // Outputs show the value after the current step so the last step can be consumed directly.
  assign quotient  = quo_n;
  assign remainder = rem_n;
  assign done      = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dsor_q <= '0;
    end else if (start) begin
      cnt_q  <= CNT_W'(XLEN);
      quo_q  <= dividend;
      rem_q  <= '0;
      dsor_q <= divisor;
    end else if (cnt_q != '0) begin
      cnt_q  <= cnt_q - 1'b1;
      quo_q  <= quo_n;
      rem_q  <= rem_n;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage integer unit: single-cycle ALU plus iterative multiply/divide behind valid/ready.
// Define ALU_MDU_FAST_MUL_EN for a single-cycle combinational multiplier.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [3:0]      flags
);

  localparam int unsigned ShW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         op_q;
  logic [XLEN-1:0]    mcand_q;
  logic [2*XLEN-1:0]  prod_q;
  logic               neg_q, rem_neg_q;
  logic [XLEN-1:0]    result_q, res_d;
  logic [3:0]         flags_q, flags_d;
  logic               c_d, v_d, load_res;

  logic               accept, go_calc, is_mul, is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]    mag_a, mag_b;
  logic               div_zero, div_ovf;
  logic [XLEN-1:0]    corner_res, simple_res, idle_res, calc_res;
  logic               simple_c, simple_v, idle_c, idle_v;
  logic [XLEN:0]      add_w, sub_w, mul_sum;
  logic [ShW-1:0]     shamt;
  logic [2*XLEN-1:0]  prod_step, prod_fix;
  logic [XLEN-1:0]    div_q, div_r, q_fix, r_fix;
  logic               div_done, op_q_div, calc_last;

  function automatic logic [XLEN-1:0] mul_pick(logic [4:0] op, logic [2*XLEN-1:0] p);
    return (op == OpMul) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  assign accept   = in_valid && (state_q == StIdle) && !kill;
  assign in_ready = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result   = result_q;
  assign flags    = flags_q;

  // Operand decode shared by multiply and divide.
  assign is_mul   = (alu_op >= OpMul) && (alu_op <= OpMulhu);
  assign is_div   = (alu_op >= OpDiv) && (alu_op <= OpRemu);
  assign a_signed = alu_op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
  assign b_signed = alu_op inside {OpMul, OpMulh, OpDiv, OpRem};
  assign a_neg    = a_signed && src_a[XLEN-1];
  assign b_neg    = b_signed && src_b[XLEN-1];
  assign mag_a    = a_neg ? -src_a : src_a;
  assign mag_b    = b_neg ? -src_b : src_b;

  assign div_zero = is_div && (src_b == '0);
  assign div_ovf  = ((alu_op == OpDiv) || (alu_op == OpRem)) && (src_a == MinNeg) && (&src_b);

  always_comb begin
    corner_res = '0;
    if (div_zero) begin
      corner_res = ((alu_op == OpDiv) || (alu_op == OpDivu)) ? '1 : src_a;
    end else if (alu_op == OpDiv) begin
      corner_res = src_a;
    end
  end

  assign add_w = {1'b0, src_a} + {1'b0, src_b};
  assign sub_w = {1'b0, src_a} - {1'b0, src_b};
  assign shamt = src_b[ShW-1:0];

  always_comb begin
    simple_res = '0;
    simple_c   = 1'b0;
    simple_v   = 1'b0;
    case (alu_op)
      OpAdd: begin
        simple_res = add_w[XLEN-1:0];
        simple_c   = add_w[XLEN];
        simple_v   = (src_a[XLEN-1] == src_b[XLEN-1]) && (add_w[XLEN-1] != src_a[XLEN-1]);
      end
      OpSub: begin
        simple_res = sub_w[XLEN-1:0];
        simple_c   = ~sub_w[XLEN];
        simple_v   = (src_a[XLEN-1] != src_b[XLEN-1]) && (sub_w[XLEN-1] != src_a[XLEN-1]);
      end
      OpAnd:  simple_res = src_a & src_b;
      OpOr:   simple_res = src_a | src_b;
      OpXor:  simple_res = src_a ^ src_b;
      OpSlt:  simple_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      OpSltu: simple_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      OpSll:  simple_res = src_a << shamt;
      OpSrl:  simple_res = src_a >> shamt;
      OpSra:  simple_res = $signed(src_a) >>> shamt;
      default: simple_res = '0;
    endcase
  end

`ifdef ALU_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_raw, fast_prod;
  assign fast_raw  = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
  assign fast_prod = (a_neg ^ b_neg) ? -fast_raw : fast_raw;
  assign go_calc   = is_div && !div_zero && !div_ovf;
`else
  assign go_calc   = is_mul || (is_div && !div_zero && !div_ovf);
`endif

  always_comb begin
    idle_res = simple_res;
    idle_c   = simple_c;
    idle_v   = simple_v;
    if (div_zero || div_ovf) begin
      idle_res = corner_res;
      idle_c   = 1'b0;
      idle_v   = 1'b0;
    end
`ifdef ALU_MDU_FAST_MUL_EN
    else if (is_mul) begin
      idle_res = mul_pick(alu_op, fast_prod);
      idle_c   = 1'b0;
      idle_v   = 1'b0;
    end
`endif
  end

  // Shift-add: conditionally add the multiplicand to the upper half, then shift right.
  assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_step = {mul_sum, prod_q[XLEN-1:1]};
  assign prod_fix  = neg_q ? -prod_step : prod_step;

  alu_mdu_divider #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept && go_calc && is_div),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (div_q),
    .remainder (div_r),
    .done      (div_done)
  );

  assign q_fix     = neg_q ? -div_q : div_q;
  assign r_fix     = rem_neg_q ? -div_r : div_r;
  assign op_q_div  = (op_q >= OpDiv);
  assign calc_last = op_q_div ? div_done : (cnt_q == CNT_W'(1));
  assign calc_res  = !op_q_div ? mul_pick(op_q, prod_fix) :
                     ((op_q == OpDiv) || (op_q == OpDivu)) ? q_fix : r_fix;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_res = 1'b0;
    res_d    = idle_res;
    c_d      = idle_c;
    v_d      = idle_v;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (go_calc) begin
            state_d = StCalc;
            cnt_d   = CNT_W'(XLEN);
          end else begin
            state_d  = StDone;
            load_res = 1'b1;
          end
        end
      end
      StCalc: begin
        res_d = calc_res;
        c_d   = 1'b0;
        v_d   = 1'b0;
        if (kill) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (calc_last) begin
            state_d  = StDone;
            load_res = 1'b1;
          end
        end
      end
      StDone: begin
        if (kill || out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    flags_d        = '0;
    flags_d[FlagN] = res_d[XLEN-1];
    flags_d[FlagZ] = (res_d == '0);
    flags_d[FlagC] = c_d;
    flags_d[FlagV] = v_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= '0;
      mcand_q   <= '0;
      prod_q    <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept && go_calc) begin
        op_q      <= alu_op;
        mcand_q   <= mag_a;
        prod_q    <= {{XLEN{1'b0}}, mag_b};
        neg_q     <= a_neg ^ b_neg;
        rem_neg_q <= a_neg;
      end else if (state_q == StCalc) begin
        prod_q <= prod_step;
      end
      if (load_res) begin
        result_q <= res_d;
        flags_q  <= flags_d;
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Randomized self-checking bench for alu_mdu against an arithmetic reference model.
module tb_alu_mdu;
  import alu_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int ITER_LAT = XLEN + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [4:0]      alu_op = '0;
  logic [XLEN-1:0] src_a = '0;
  logic [XLEN-1:0] src_b = '0;
  logic            kill = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic [3:0]      flags;

  int checks = 0;
  int failures = 0;

  alu_mdu #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model straight from the RISC-V arithmetic rules.
  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [3:0] f, output int lat);
    longint sa, sb, ua, ub, s;
    logic [63:0] p;
    logic c, v;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    c = 1'b0;
    v = 1'b0;
    lat = 1;
    r = '0;
    case (op)
      OpAdd: begin
        p = ua + ub; r = p[31:0]; c = p[32];
        s = sa + sb; v = (s != longint'($signed(r)));
      end
      OpSub: begin
        r = a - b; c = (a >= b);
        s = sa - sb; v = (s != longint'($signed(r)));
      end
      OpAnd:  r = a & b;
      OpOr:   r = a | b;
      OpXor:  r = a ^ b;
      OpSlt:  r = {31'b0, sa < sb};
      OpSltu: r = {31'b0, a < b};
      OpSll:  r = a << b[4:0];
      OpSrl:  r = a >> b[4:0];
      OpSra:  r = $signed(a) >>> b[4:0];
      OpMul:    begin p = sa * sb; r = p[31:0];  lat = ITER_LAT; end
      OpMulh:   begin p = sa * sb; r = p[63:32]; lat = ITER_LAT; end
      OpMulhsu: begin p = sa * ub; r = p[63:32]; lat = ITER_LAT; end
      OpMulhu:  begin p = ua * ub; r = p[63:32]; lat = ITER_LAT; end
      OpDiv: begin
        if (b == 0) r = '1;
        else if (a == 32'h8000_0000 && b == 32'hffff_ffff) r = a;
        else begin s = sa / sb; r = s[31:0]; lat = ITER_LAT; end
      end
      OpDivu: begin
        if (b == 0) r = '1;
        else begin s = ua / ub; r = s[31:0]; lat = ITER_LAT; end
      end
      OpRem: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hffff_ffff) r = '0;
        else begin s = sa % sb; r = s[31:0]; lat = ITER_LAT; end
      end
      OpRemu: begin
        if (b == 0) r = a;
        else begin s = ua % ub; r = s[31:0]; lat = ITER_LAT; end
      end
      default: r = '0;
    endcase
`ifdef ALU_MDU_FAST_MUL_EN
    if (op >= OpMul && op <= OpMulhu) lat = 1;
`endif
    f = {r[31], r == 0, c, v};
  endfunction

  task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    alu_op = op; src_a = a; src_b = b; in_valid = 1'b1;
    check_eq("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold);
    logic [31:0] er;
    logic [3:0]  ef;
    int exp_lat, lat;
    logic busy_ready;
    model(op, a, b, er, ef, exp_lat);
    start_op(op, a, b);
    lat = 0;
    busy_ready = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (in_ready) busy_ready = 1'b1;
    end while (!out_valid && lat < 100);
    check_eq($sformatf("lat op%0d", op), lat, exp_lat);
    check_eq($sformatf("busy_in_ready op%0d", op), busy_ready, 0);
    check_eq($sformatf("result op%0d a=%0h b=%0h", op, a, b), result, er);
    check_eq($sformatf("flags op%0d a=%0h b=%0h", op, a, b), flags, ef);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_in_ready", in_ready, 0);
      check_eq("hold_result", result, er);
      check_eq("hold_flags", flags, ef);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("consumed_valid", out_valid, 0);
    check_eq("consumed_in_ready", in_ready, 1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hffff_ffff;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic seen;
    logic [4:0] rop;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_flags", flags, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", in_ready, 1);
    check_eq("post_rst_out_valid", out_valid, 0);

    do_op(OpAdd, 32'h7fff_ffff, 32'h1, 0);
    do_op(OpSub, 32'd5, 32'd5, 0);
    do_op(OpSltu, 32'd1, 32'hffff_ffff, 0);
    do_op(OpMulh, 32'hffff_ffff, 32'hffff_ffff, 0);
    do_op(OpDiv, 32'h8000_0000, 32'hffff_ffff, 0);
    do_op(OpDivu, 32'd7, 32'd0, 0);
    do_op(OpRem, 32'hffff_fff9, 32'd2, 0);
    do_op(OpRsv18, 32'h1234, 32'h5678, 0);
    do_op(OpSra, 32'h8000_00f0, 32'h24, 5);
    do_op(OpMulhsu, 32'hffff_fffe, 32'hffff_ffff, 5);

    // Kill mid-divide: result must never be presented.
    start_op(OpDivu, 32'd1000, 32'd7);
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check_eq("kill_calc_in_ready", in_ready, 1);
    check_eq("kill_calc_valid", out_valid, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_eq("kill_calc_never_valid", seen, 0);

    start_op(OpAdd, 32'd3, 32'd4);
    @(negedge clk);
    check_eq("kill_done_pre_valid", out_valid, 1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check_eq("kill_done_valid", out_valid, 0);
    check_eq("kill_done_in_ready", in_ready, 1);

    alu_op = OpAdd; in_valid = 1'b1; kill = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; kill = 1'b0;
    check_eq("kill_idle_valid", out_valid, 0);
    check_eq("kill_idle_in_ready", in_ready, 1);

    // Asynchronous reset in the middle of a multiply.
    start_op(OpMulhu, 32'hffff_ffff, 32'hffff_ffff);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_in_ready", in_ready, 1);
    check_eq("rst_mid_valid", out_valid, 0);
    check_eq("rst_mid_result", result, 0);
    check_eq("rst_mid_flags", flags, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(OpMulhu, 32'hffff_ffff, 32'hffff_ffff, 0);

    for (int i = 0; i < 60; i++) begin
      rop = $urandom_range(0, 1) ? 5'($urandom_range(10, 17)) : 5'($urandom_range(0, 31));
      do_op(rop, pick(), pick(), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
